// File: rtl/fetch_stage.sv
// Fetch front end: owns pc_F, issues credit-limited requests to a variable-latency imem, queues words in order,
// and feeds the IF/ID register (request-to-decode >= L+2 cycles); issue stalls when requests plus buffered words reach DEPTH.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_F,
  input  logic        pcsrc_E,
  input  logic [31:0] pctarget_E,
  input  logic        stall_D,
  input  logic        flush_D,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pcplus4_D,
  output logic        valid_D
);

  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW  = AW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, qcnt_q, qcnt_d;
  logic [31:0]   instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic          vld_q, vld_d;

  logic [31:0]   tag_mem  [DEPTH];
  logic [31:0]   iq_instr [DEPTH];
  logic [31:0]   iq_pc    [DEPTH];

  logic [CW-1:0] occ;
  logic          acc, rsp_keep, rsp_drop, iq_pop;
  logic          unused_tgt_lsb;

  assign unused_tgt_lsb = ^pctarget_E[1:0];

  // Credit covers words in flight, words to be discarded and words buffered.
  assign occ            = out_q + drop_q + qcnt_q;
  assign imem_req_valid = reset && (occ < CW'(DEPTH)) && !pcsrc_E;
  assign imem_req_addr  = pc_q;
  assign pc_F           = pc_q;

  assign acc      = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (pcsrc_E || (drop_q != '0));
  assign rsp_keep = imem_rsp_valid && !pcsrc_E && (drop_q == '0);
  assign iq_pop   = !pcsrc_E && !flush_D && !stall_D && (qcnt_q != '0);

  always_comb begin
    pc_d     = pc_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    iq_wr_d  = iq_wr_q;
    iq_rd_d  = iq_rd_q;
    out_d    = out_q;
    drop_d   = drop_q;
    qcnt_d   = qcnt_q;
    if (pcsrc_E) begin
      pc_d     = {pctarget_E[31:2], 2'b00};
      tag_wr_d = '0;
      tag_rd_d = '0;
      iq_wr_d  = '0;
      iq_rd_d  = '0;
      out_d    = '0;
      qcnt_d   = '0;
      // Everything still in flight becomes stale; a word landing now is already accounted for.
      drop_d   = drop_q + out_q - CW'(imem_rsp_valid);
    end else begin
      if (acc) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = tag_wr_q + AW'(1);
      end
      if (rsp_keep) begin
        tag_rd_d = tag_rd_q + AW'(1);
        iq_wr_d  = iq_wr_q + AW'(1);
      end
      if (iq_pop) iq_rd_d = iq_rd_q + AW'(1);
      out_d  = out_q + CW'(acc) - CW'(rsp_keep);
      drop_d = drop_q - CW'(rsp_drop);
      qcnt_d = qcnt_q + CW'(rsp_keep) - CW'(iq_pop);
    end
  end

  always_comb begin
    instr_d = NOP;
    pcd_d   = '0;
    pcp4_d  = '0;
    vld_d   = 1'b0;
    if (!pcsrc_E && !flush_D) begin
      if (stall_D) begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        vld_d   = vld_q;
      end else if (qcnt_q != '0) begin
        instr_d = iq_instr[iq_rd_q];
        pcd_d   = iq_pc[iq_rd_q];
        pcp4_d  = iq_pc[iq_rd_q] + 32'd4;
        vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) tag_mem[tag_wr_q] <= pc_q;
    if (rsp_keep) begin
      iq_instr[iq_wr_q] <= imem_rsp_data;
      iq_pc[iq_wr_q]    <= tag_mem[tag_rd_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      iq_wr_q  <= '0;
      iq_rd_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      qcnt_q   <= '0;
      instr_q  <= NOP;
      pcd_q    <= '0;
      pcp4_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      iq_wr_q  <= iq_wr_d;
      iq_rd_q  <= iq_rd_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      qcnt_q   <= qcnt_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      pcp4_q   <= pcp4_d;
      vld_q    <= vld_d;
    end
  end

  assign instr_D   = instr_q;
  assign pc_D      = pcd_q;
  assign pcplus4_D = pcp4_q;
  assign valid_D   = vld_q;

  a_occ_bound: assert property (@(posedge clk) disable iff (!reset) occ <= CW'(DEPTH));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
                                   imem_rsp_valid |-> ((out_q != '0) || (drop_q != '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fixed-latency in-order memory model, per-cycle vector table plus multi-cycle sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc_F;
  logic        pcsrc_E, stall_D, flush_D;
  logic [31:0] pctarget_E;
  logic [31:0] instr_D, pc_D, pcplus4_D;
  logic        valid_D;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_F(pc_F), .pcsrc_E(pcsrc_E), .pctarget_E(pctarget_E),
    .stall_D(stall_D), .flush_D(flush_D),
    .instr_D(instr_D), .pc_D(pc_D), .pcplus4_D(pcplus4_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, ps;
    logic [31:0] tg;
    logic        rv;
    logic [31:0] addr;
    logic        vd;
    logic [31:0] pcd;
  } vec_t;

  vec_t        tbl [30];
  int          errs = 0;
  int          nchk = 0;
  int          cyc  = 0;
  int          lat  = 1;
  int          pend_due [$];
  logic [31:0] pend_addr [$];

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic st, fl, ps, input logic [31:0] tg,
                              input logic rv, input logic [31:0] addr, input logic vd, input logic [31:0] pcd);
    vec_t v;
    v.st = st; v.fl = fl; v.ps = ps; v.tg = tg; v.rv = rv; v.addr = addr; v.vd = vd; v.pcd = pcd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic ps, input logic [31:0] tg, input logic rd);
    @(negedge clk);
    stall_D = st; flush_D = fl; pcsrc_E = ps; pctarget_E = tg; imem_req_ready = rd;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = wd(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic end_cycle();
    if (imem_req_valid && imem_req_ready) begin
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(imem_req_addr);
    end
    cyc++;
  endtask

  task automatic assert_reset();
    #1;
    reset = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    stall_D = 1'b0; flush_D = 1'b0; pcsrc_E = 1'b0; pctarget_E = '0;
    pend_due.delete();
    pend_addr.delete();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, "_vd"},    32'(valid_D), 32'd0);
    chk({nm, "_instr"}, instr_D, NOP);
    chk({nm, "_pcd"},   pc_D, 32'd0);
    chk({nm, "_pcp4"},  pcplus4_D, 32'd0);
  endtask

  initial begin
    int issued, shown;
    logic [31:0] nxt;

    reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    stall_D = 1'b0; flush_D = 1'b0; pcsrc_E = 1'b0; pctarget_E = '0;

    // L=1 stream: stall 6..10, redirect at 17, flush at 23, flush+stall at 27.
    tbl[0]  = mk(0,0,0,0,        1,32'h000,0,32'h000);
    tbl[1]  = mk(0,0,0,0,        1,32'h004,0,32'h000);
    tbl[2]  = mk(0,0,0,0,        1,32'h008,0,32'h000);
    tbl[3]  = mk(0,0,0,0,        1,32'h00C,1,32'h000);
    tbl[4]  = mk(0,0,0,0,        1,32'h010,1,32'h004);
    tbl[5]  = mk(0,0,0,0,        1,32'h014,1,32'h008);
    tbl[6]  = mk(1,0,0,0,        1,32'h018,1,32'h00C);
    tbl[7]  = mk(1,0,0,0,        1,32'h01C,1,32'h00C);
    tbl[8]  = mk(1,0,0,0,        0,32'h000,1,32'h00C);
    tbl[9]  = mk(1,0,0,0,        0,32'h000,1,32'h00C);
    tbl[10] = mk(1,0,0,0,        0,32'h000,1,32'h00C);
    tbl[11] = mk(0,0,0,0,        0,32'h000,1,32'h00C);
    tbl[12] = mk(0,0,0,0,        1,32'h020,1,32'h010);
    tbl[13] = mk(0,0,0,0,        1,32'h024,1,32'h014);
    tbl[14] = mk(0,0,0,0,        1,32'h028,1,32'h018);
    tbl[15] = mk(0,0,0,0,        1,32'h02C,1,32'h01C);
    tbl[16] = mk(0,0,0,0,        1,32'h030,1,32'h020);
    tbl[17] = mk(0,0,1,32'h203,  0,32'h000,1,32'h024);
    tbl[18] = mk(0,0,0,0,        1,32'h200,0,32'h000);
    tbl[19] = mk(0,0,0,0,        1,32'h204,0,32'h000);
    tbl[20] = mk(0,0,0,0,        1,32'h208,0,32'h000);
    tbl[21] = mk(0,0,0,0,        1,32'h20C,1,32'h200);
    tbl[22] = mk(0,0,0,0,        1,32'h210,1,32'h204);
    tbl[23] = mk(0,1,0,0,        1,32'h214,1,32'h208);
    tbl[24] = mk(0,0,0,0,        1,32'h218,0,32'h000);
    tbl[25] = mk(0,0,0,0,        1,32'h21C,1,32'h20C);
    tbl[26] = mk(0,0,0,0,        1,32'h220,1,32'h210);
    tbl[27] = mk(1,1,0,0,        1,32'h224,1,32'h214);
    tbl[28] = mk(0,0,0,0,        0,32'h000,0,32'h000);
    tbl[29] = mk(0,0,0,0,        1,32'h228,1,32'h218);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rv", 32'(imem_req_valid), 32'd0);
    chk("rst_pcf", pc_F, 32'h0);
    chk_bubble("rst");
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].ps, tbl[i].tg, 1'b1);
      chk($sformatf("t%0d_rv", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("t%0d_addr", i), imem_req_addr, tbl[i].addr);
        chk($sformatf("t%0d_pcf", i), pc_F, tbl[i].addr);
      end
      chk($sformatf("t%0d_vd", i), 32'(valid_D), 32'(tbl[i].vd));
      chk($sformatf("t%0d_pcd", i), pc_D, tbl[i].pcd);
      chk($sformatf("t%0d_instr", i), instr_D, tbl[i].vd ? wd(tbl[i].pcd) : NOP);
      chk($sformatf("t%0d_pcp4", i), pcplus4_D, tbl[i].vd ? tbl[i].pcd + 32'd4 : 32'd0);
      end_cycle();
    end

    // L=3: credit throttles issue; stream must stay in order with no loss.
    assert_reset();
    lat = 3;
    release_reset();
    issued = 0; shown = 0; nxt = 32'h0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (valid_D) begin
        chk($sformatf("l3_c%0d_pcd", c), pc_D, nxt);
        chk($sformatf("l3_c%0d_instr", c), instr_D, wd(nxt));
        nxt = nxt + 32'd4;
        shown++;
      end
      chk($sformatf("l3_c%0d_occ_bound", c), 32'((issued - shown) <= 4), 32'd1);
      chk($sformatf("l3_c%0d_rv", c), 32'(imem_req_valid), 32'((issued - shown) < 4));
      if (imem_req_valid && imem_req_ready) issued++;
      end_cycle();
    end
    chk("l3_throughput", 32'(shown >= 20), 32'd1);

    // L=2: redirect with two requests in flight, one landing in the redirect cycle.
    assert_reset();
    lat = 2;
    release_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_c0_addr", imem_req_addr, 32'h0);
    end_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_c1_addr", imem_req_addr, 32'h4);
    end_cycle();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    chk("rd_c2_rsp_present", 32'(imem_rsp_valid), 32'd1);
    chk("rd_c2_rv", 32'(imem_req_valid), 32'd0);
    end_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_c3_rv", 32'(imem_req_valid), 32'd1);
    chk("rd_c3_pcf", pc_F, 32'h100);
    chk("rd_c3_addr", imem_req_addr, 32'h100);
    chk_bubble("rd_c3");
    end_cycle();
    for (int c = 4; c < 7; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("rd_c%0d_vd", c), 32'(valid_D), 32'd0);
      end_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_c7_vd", 32'(valid_D), 32'd1);
    chk("rd_c7_pcd", pc_D, 32'h100);
    chk("rd_c7_pcp4", pcplus4_D, 32'h104);
    chk("rd_c7_instr", instr_D, wd(32'h100));
    end_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_c8_pcd", pc_D, 32'h104);
    end_cycle();

    // L=1: asynchronous reset mid-stream with a request outstanding.
    assert_reset();
    lat = 1;
    release_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      end_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("mr_pre_vd", 32'(valid_D), 32'd1);
    chk("mr_pre_pcd", pc_D, 32'h8);
    assert_reset();
    chk("mr_rv", 32'(imem_req_valid), 32'd0);
    chk("mr_pcf", pc_F, 32'h0);
    chk_bubble("mr");
    release_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("mr_c%0d_rv", c), 32'(imem_req_valid), 32'd1);
      chk($sformatf("mr_c%0d_addr", c), imem_req_addr, 32'(c * 4));
      chk($sformatf("mr_c%0d_vd", c), 32'(valid_D), 32'(c == 3));
      if (c == 3) chk("mr_c3_pcd", pc_D, 32'h0);
      end_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the segmented RISC-V core; drives the `instr_D`, `pc_D` and `pcplus4_D` inputs of the datapath.
- Owns the fetch PC and issues requests to a variable-latency instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small in-order queue, then presents them through the IF/ID pipeline register.
- Honours decode stall/flush and execute-stage branch/jump redirects, and discards in-flight responses made stale by a redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, max instructions in flight plus buffered (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address (= pc_F).
- imem_rsp_valid  in  1  response valid; in order; no backpressure.
- imem_rsp_data  in  32  instruction word.
- pc_F  out  32  current fetch PC.
- pcsrc_E  in  1  redirect from EX (taken branch/jump).
- pctarget_E  in  32  redirect target; bits [1:0] ignored.
- stall_D  in  1  hold IF/ID register.
- flush_D  in  1  bubble IF/ID register.
- instr_D  out  32  decode instruction.
- pc_D  out  32  PC of instr_D.
- pcplus4_D  out  32  pc_D + 4.
- valid_D  out  1  instr_D is a real fetched instruction.

## Operation
- State: pc_F, tag queue (PC per request, DEPTH entries), instruction queue (DEPTH entries), outstanding count, drop count, IF/ID register.
- Credit: occ = outstanding + drop_cnt + queue_count, all registered values. imem_req_valid = (occ < DEPTH) & !pcsrc_E. Deassert during reset.
- Request accept (valid & ready): push pc_F into tag queue, outstanding+1, pc_F <= pc_F + 4 (mod 2^32).
- Response:
  - drop_cnt > 0: discard the word, drop_cnt−1.
  - Otherwise: pair the word with the tag head, push it into the instruction queue, outstanding−1.
- IF/ID update, in priority order:
  - pcsrc_E or flush_D: bubble.
  - Else stall_D: hold.
  - Else queue non-empty: pop head, valid_D=1.
  - Else: bubble.
- Bubble values: instr_D=32'h0000_0013 (NOP), pc_D=0, pcplus4_D=0, valid_D=0.
- Redirect (pcsrc_E=1):
  - pc_F <= {pctarget_E[31:2],2'b00}.
  - Queues cleared.
  - drop_cnt <= drop_cnt + outstanding − (response arriving this cycle ? 1 : 0); outstanding <= 0.
  - A response arriving this cycle is discarded.
  - No request is issued this cycle.
- Reset (async, any time):
  - pc_F=RESET_PC; counts=0; queues empty.
  - IF/ID at bubble values; imem_req_valid=0.
  - The memory shares the reset, so no stale responses follow.
- Invariant: occ ≤ DEPTH at all times; occ > DEPTH or a response arriving with outstanding=drop_cnt=0 is an assertion failure.

## Timing
- Request accepted in cycle t, memory latency L ≥ 1 (response in cycle t+L):
  - word enters the queue at the end of t+L;
  - loaded into IF/ID at the end of t+L+1, given no stall;
  - visible on instr_D in cycle t+L+2.
- No queue bypass; minimum request-to-decode latency is L+2 cycles.
- DEPTH ≥ L+2 sustains one instruction per cycle; smaller DEPTH throttles issue.
- imem_req_valid depends only on registers and pcsrc_E, never on stall_D/flush_D.
- First cycle after reset release: imem_req_valid=1, imem_req_addr=RESET_PC.
- Redirect in cycle r: first request to the target is in cycle r+1; the IF/ID register shows a bubble in cycle r+1.
- Simultaneous pcsrc_E, flush_D and stall_D: bubble.
- Simultaneous request accept and response: both take effect; outstanding unchanged.

## Test plan
- Reset, always-ready memory with L=1, no stalls:
  - imem_req_addr shows 0x0, 0x4, 0x8, … on consecutive cycles.
  - instr_D matches each word with pc_D correct from cycle 3.
  - valid_D stays high every cycle thereafter.
- L=3, DEPTH=4:
  - at most 4 outstanding plus buffered; imem_req_valid drops when occ=4;
  - no word lost or reordered.
- stall_D high for 5 cycles mid-stream:
  - instr_D/pc_D hold;
  - the queue fills, then imem_req_valid=0;
  - after release, sequential PCs resume with no gap or duplicate.
- Redirect to 0x0000_0103 with 2 responses in flight (L=2):
  - pc_F becomes 0x100;
  - both stale responses are discarded and the bubble has valid_D=0;
  - the next valid instr_D has pc_D=0x100, pcplus4_D=0x104.
- Coincident events in one cycle:
  - flush_D with stall_D → bubble.
  - Redirect with a response arriving → that response is dropped and drop_cnt excludes it.
- Assert reset low mid-stream with outstanding requests:
  - outputs go immediately to reset values;
  - after release, fetch restarts at RESET_PC.
